// File: rtl/pump_duty_decoder.sv
// Charge-pump PWM duty decoder: counts high samples and rising edges per window,
// publishes them once per window and flags when the duty has settled.
module pump_duty_decoder #(
  parameter int WINDOW         = 32000,
  parameter int TOL            = 2,
  parameter int STABLE_WINDOWS = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        pump_in,
  output logic [23:0] duty_out,
  output logic [23:0] edge_count_out,
  output logic        duty_valid,
  output logic        stable_out
);

  localparam int SW = $clog2(STABLE_WINDOWS + 1);
  localparam logic [23:0] LAST = 24'(WINDOW - 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_WINDOWS);
  localparam logic [24:0] TOLV = 25'(TOL);

  logic [23:0]   r_win_cnt;
  logic [23:0]   r_high_cnt;
  logic [23:0]   r_edge_cnt;
  logic          r_pump_prev;
  logic          r_have_prev;
  logic [SW-1:0] r_stable_cnt;

  logic          w_rise;
  logic          w_publish;
  logic [23:0]   w_new_duty;
  logic [23:0]   w_new_edges;
  logic [24:0]   w_diff;
  logic [24:0]   w_mag;
  logic          w_in_tol;
  logic [SW-1:0] w_stable_nxt;

  assign w_rise      = pump_in & ~r_pump_prev;
  assign w_publish   = (r_win_cnt == LAST);
  assign w_new_duty  = r_high_cnt + {23'd0, pump_in};
  assign w_new_edges = r_edge_cnt + {23'd0, w_rise};
  assign w_diff      = {1'b0, w_new_duty} - {1'b0, duty_out};
  assign w_mag       = w_diff[24] ? (~w_diff + 25'd1) : w_diff;
  assign w_in_tol    = (w_mag <= TOLV);

  // The first window after reset has nothing to compare against.
  always_comb begin
    w_stable_nxt = '0;
    if (r_have_prev && w_in_tol) begin
      if (r_stable_cnt == SMAX)
        w_stable_nxt = SMAX;
      else
        w_stable_nxt = r_stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_win_cnt      <= '0;
      r_high_cnt     <= '0;
      r_edge_cnt     <= '0;
      r_pump_prev    <= 1'b0;
      r_have_prev    <= 1'b0;
      r_stable_cnt   <= '0;
      duty_out       <= '0;
      edge_count_out <= '0;
      duty_valid     <= 1'b0;
      stable_out     <= 1'b0;
    end else begin
      r_pump_prev <= pump_in;
      duty_valid  <= w_publish;
      if (w_publish) begin
        duty_out       <= w_new_duty;
        edge_count_out <= w_new_edges;
        r_high_cnt     <= '0;
        r_edge_cnt     <= '0;
        r_win_cnt      <= '0;
        r_have_prev    <= 1'b1;
        r_stable_cnt   <= w_stable_nxt;
        stable_out     <= (w_stable_nxt == SMAX);
      end else begin
        r_high_cnt <= w_new_duty;
        r_edge_cnt <= w_new_edges;
        r_win_cnt  <= r_win_cnt + 24'd1;
      end
    end
  end

endmodule
